// File: rtl/zigbee_pad_host.sv
// zigbee_pad_host: drives the chip's pad-mux select/input pins per command and returns a filtered sample of its output pins
module zigbee_pad_host #(
    parameter int SETUP_CYCLES   = 4,
    parameter int STABLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_sel_i,
    input  logic [21:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [17:0] rsp_data_o,
    output logic        rsp_timeout_o,
    output logic [1:0]  rsp_sel_o,
    output logic [1:0]  pad_sel_o,
    output logic [21:0] pad_in_o,
    input  logic [17:0] pad_out_i,
    output logic        busy_o
);
    localparam logic [7:0]  SETUP_LAST = 8'(SETUP_CYCLES - 1);
    localparam logic [3:0]  STABLE_N   = 4'(STABLE_CYCLES);
    localparam logic [15:0] TIMEOUT_N  = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, SAMPLE, RESP} state_t;

    state_t      state;
    logic [17:0] sync1_q;
    logic [17:0] sync_q;
    logic [17:0] prev_q;
    logic [7:0]  setup_cnt;
    logic [3:0]  stable_cnt;
    logic [15:0] timeout_cnt;
    logic [3:0]  stable_nxt;
    logic [15:0] timeout_nxt;
    logic        stable_hit;
    logic        timeout_hit;

    assign busy_o = (state != IDLE);

    // Next values of the saturating sample counters and the two exit conditions
    always_comb begin
        stable_nxt  = (sync_q == prev_q) ? ((stable_cnt == 4'hF) ? stable_cnt : stable_cnt + 4'd1) : 4'd1;
        timeout_nxt = (timeout_cnt == 16'hFFFF) ? timeout_cnt : timeout_cnt + 16'd1;
        stable_hit  = (stable_nxt >= STABLE_N);
        timeout_hit = (timeout_nxt >= TIMEOUT_N);
    end

    // Two-flop synchroniser for the chip output pins, which are asynchronous to clk_i
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= pad_out_i;
            sync_q  <= sync1_q;
        end
    end

    // Command sequencer: present pads, wait setup, filter samples, hold response until consumed
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state         <= IDLE;
            cmd_ready_o   <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= '0;
            rsp_timeout_o <= 1'b0;
            rsp_sel_o     <= '0;
            pad_sel_o     <= '0;
            pad_in_o      <= '0;
            prev_q        <= '0;
            setup_cnt     <= '0;
            stable_cnt    <= '0;
            timeout_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready_o <= !(cmd_valid_i && cmd_ready_o);
                    if (cmd_valid_i && cmd_ready_o) begin
                        rsp_sel_o   <= cmd_sel_i;
                        prev_q      <= '0;
                        setup_cnt   <= '0;
                        stable_cnt  <= '0;
                        timeout_cnt <= '0;
                        if (cmd_sel_i == 2'd0) begin
                            rsp_data_o    <= '0;
                            rsp_timeout_o <= 1'b0;
                            rsp_valid_o   <= 1'b1;
                            state         <= RESP;
                        end else begin
                            pad_sel_o <= cmd_sel_i;
                            pad_in_o  <= cmd_data_i;
                            state     <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (setup_cnt >= SETUP_LAST) state <= SAMPLE;
                    else setup_cnt <= setup_cnt + 8'd1;
                end
                SAMPLE: begin
                    stable_cnt  <= stable_nxt;
                    timeout_cnt <= timeout_nxt;
                    prev_q      <= sync_q;
                    if (stable_hit || timeout_hit) begin
                        rsp_data_o    <= sync_q;
                        rsp_timeout_o <= !stable_hit;
                        rsp_valid_o   <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        pad_sel_o   <= '0;
                        cmd_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_zigbee_pad_host.sv
// tb_zigbee_pad_host: scoreboard bench for the pad-mux host driver
module tb_zigbee_pad_host;
    localparam int SETUP   = 4;
    localparam int STABLE  = 3;
    localparam int TIMEOUT = 255;

    typedef struct {
        logic [1:0]  sel;
        logic [17:0] data;
        logic        to;
        int          lat;
        logic        tog;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_sel = '0;
    logic [21:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [17:0] rsp_data;
    logic        rsp_timeout;
    logic [1:0]  rsp_sel;
    logic [1:0]  pad_sel;
    logic [21:0] pad_in;
    logic [17:0] pad_val = '0;
    logic [17:0] tog_val = 18'd1;
    logic        tog_en = 1'b0;
    logic [17:0] pad_out;
    logic        busy;

    exp_t sb[$];
    exp_t e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic rv_prev = 1'b0;

    zigbee_pad_host #(.SETUP_CYCLES(SETUP), .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_i(clk), .resetn_i(resetn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_sel_i(cmd_sel), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_timeout_o(rsp_timeout), .rsp_sel_o(rsp_sel),
        .pad_sel_o(pad_sel), .pad_in_o(pad_in), .pad_out_i(pad_out), .busy_o(busy)
    );

    always #5 clk = ~clk;

    assign pad_out = tog_en ? tog_val : pad_val;

    always @(posedge clk) cyc <= cyc + 1;

    // chip output toggling between 1 and 2 every cycle, changing just after the edge
    always @(posedge clk) begin
        #1;
        tog_val = (tog_val == 18'd1) ? 18'd2 : 18'd1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // accept/response monitor: latency and response content against the scoreboard
    always @(negedge clk) begin
        if (!resetn) begin
            rv_prev = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc;
                if (sb.size() > 0 && sb[sb.size()-1].tog)
                    sb[sb.size()-1].data = ((SETUP + TIMEOUT) % 2 == 0) ? pad_out :
                                           ((pad_out == 18'd1) ? 18'd2 : 18'd1);
            end
            if (rsp_valid && !rv_prev) begin
                if (sb.size() > 0) check("latency", cyc - acc_cyc, sb[0].lat);
                else check("unexpected_rsp", 1, 0);
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_timeout", rsp_timeout, e.to);
                check("rsp_sel", rsp_sel, e.sel);
            end
            rv_prev = rsp_valid;
        end
    end

    task automatic send(input logic [1:0] s, input logic [21:0] d, input logic [17:0] exp_d,
                        input logic t, input int lat);
        int n;
        sb.push_back(exp_t'{s, (s == 2'd0) ? 18'd0 : exp_d, t, lat, t});
        cmd_sel = s;
        cmd_data = d;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 100);
        if (!cmd_ready) check("accept_wait", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, acc, last;
        #2;
        check("rst_ready", cmd_ready, 0);
        check("rst_pad_sel", pad_sel, 0);
        check("rst_pad_in", pad_in, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1 check("idle_ready", cmd_ready, 1);

        // stable value, default latency
        pad_val = 18'h15A5A;
        repeat (3) @(posedge clk);
        #1;
        send(2'd1, 22'h2AAAAA, 18'h15A5A, 1'b0, 1 + SETUP + STABLE);
        check("t1_pad_sel", pad_sel, 1);
        check("t1_pad_in", pad_in, 22'h2AAAAA);
        check("t1_busy", busy, 1);
        check("t1_ready_low", cmd_ready, 0);
        wait_drain();
        check("t1_pad_sel_idle", pad_sel, 0);
        check("t1_pad_in_kept", pad_in, 22'h2AAAAA);

        // never-stable input runs into the timeout
        tog_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(2'd3, 22'h0F0F0F, 18'h0, 1'b1, 1 + SETUP + TIMEOUT);
        wait_drain();
        tog_en = 1'b0;

        // single glitch restarts the stability count
        pad_val = 18'h3FFFF;
        repeat (4) @(posedge clk);
        #1;
        send(2'd2, 22'h123456, 18'h3FFFF, 1'b0, 1 + SETUP + STABLE + 2);
        repeat (3) @(posedge clk);
        #1 pad_val = 18'h0AAAA;
        @(posedge clk);
        #1 pad_val = 18'h3FFFF;
        wait_drain();

        // response back-pressure with a command waiting
        rsp_ready = 1'b0;
        pad_val = 18'h0C3C3;
        repeat (3) @(posedge clk);
        #1;
        send(2'd1, 22'h000155, 18'h0C3C3, 1'b0, 1 + SETUP + STABLE);
        sb.push_back(exp_t'{2'd2, 18'h0C3C3, 1'b0, 1 + SETUP + STABLE, 1'b0});
        cmd_sel = 2'd2;
        cmd_data = 22'h3ABCDE;
        cmd_valid = 1'b1;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t4_rsp_wait", rsp_valid, 1);
        repeat (20) begin
            @(negedge clk);
            check("t4_hold_data", rsp_data, 18'h0C3C3);
            check("t4_hold_valid", rsp_valid, 1);
            check("t4_hold_sel", rsp_sel, 1);
            check("t4_hold_ready", cmd_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_ready_after", cmd_ready, 1);
        check("t4_pad_sel_idle", pad_sel, 0);
        check("t4_idle", busy, 0);
        @(posedge clk);
        #1;
        check("t4_next_busy", busy, 1);
        check("t4_next_pad_sel", pad_sel, 2);
        cmd_valid = 1'b0;
        wait_drain();

        // back-to-back idle-select commands
        repeat (3) sb.push_back(exp_t'{2'd0, 18'h0, 1'b0, 1, 1'b0});
        cmd_sel = 2'd0;
        cmd_data = 22'h1FFFFF;
        cmd_valid = 1'b1;
        acc = 0;
        last = 0;
        n = 0;
        while (acc < 3 && n < 50) begin
            @(negedge clk);
            n++;
            if (cmd_ready) begin
                if (acc > 0) check("t5_spacing", cyc - last, 2);
                last = cyc;
                acc++;
                check("t5_pad_sel", pad_sel, 0);
                check("t5_pad_in", pad_in, 22'h3ABCDE);
            end
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("t5_accepts", acc, 3);
        wait_drain();

        // reset while sampling
        pad_val = 18'h2468A;
        repeat (3) @(posedge clk);
        #1;
        send(2'd1, 22'h155555, 18'h2468A, 1'b0, 1 + SETUP + STABLE);
        repeat (5) @(posedge clk);
        #1 check("t6_busy", busy, 1);
        resetn = 1'b0;
        #1;
        check("t6_pad_sel", pad_sel, 0);
        check("t6_pad_in", pad_in, 0);
        check("t6_ready", cmd_ready, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_rsp_timeout", rsp_timeout, 0);
        check("t6_rsp_sel", rsp_sel, 0);
        check("t6_busy_rst", busy, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        send(2'd3, 22'h0ABCDE, 18'h2468A, 1'b0, 1 + SETUP + STABLE);
        check("t6_pad_sel_new", pad_sel, 3);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/zigbee_pad_host.md
Name: zigbee_pad_host

Overview:
- Host-side driver for the zigbee chip's pad-mux test interface.
- Lives in the FPGA or emulation test platform, on the board side of the pads.
- Takes commands on a valid/ready stream and drives the chip's 2-bit select and 22-bit input pins. It then samples the chip's 18-bit output pins through a synchroniser and a stability filter, and returns one response per command.

Parameters:
- SETUP_CYCLES, 4: cycles pad_in_o/pad_sel_o are held before sampling starts (1..255).
- STABLE_CYCLES, 3: consecutive identical synchronised samples required to accept a result (1..15).
- TIMEOUT_CYCLES, 255: maximum sampling cycles before aborting with a timeout flag (STABLE_CYCLES..65535).

Ports:
- clk_i  in  1  single clock.
- resetn_i  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_sel_i  in  2  select value to present on the pads; 0 is reserved for idle.
- cmd_data_i  in  22  value to present on the chip input pins.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_data_o  out  18  accepted output-pin value.
- rsp_timeout_o  out  1  1 = no stable value within TIMEOUT_CYCLES.
- rsp_sel_o  out  2  select of the command this response answers.
- pad_sel_o  out  2  to chip sel pins.
- pad_in_o  out  22  to chip input pins.
- pad_out_i  in  18  from chip output pins; asynchronous to clk_i.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync deassert internal use):
  - State IDLE.
  - pad_sel_o=0, pad_in_o=0.
  - cmd_ready_o=0 during reset, 1 in IDLE.
  - rsp_valid_o=0, rsp_data_o=0, rsp_timeout_o=0, rsp_sel_o=0.
  - Synchroniser flops=0, all counters=0.
- pad_out_i passes through a 2-flop synchroniser; only the synchronised value (sync_q) is used.
- FSM states: IDLE, SETUP, SAMPLE, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i&cmd_ready_o: register sel/data, drive pad_sel_o/pad_in_o from the registered values on the next cycle, clear counters, go to SETUP.
  - A command with cmd_sel_i=0 is accepted and answered immediately: RESP next cycle, rsp_data_o=0, rsp_timeout_o=0, pads unchanged.
- SETUP:
  - Counts SETUP_CYCLES cycles, then goes to SAMPLE.
  - cmd_ready_o=0 in every non-IDLE state.
- SAMPLE, each cycle:
  - Compare sync_q with the previous sample. If equal, stable_cnt++; otherwise stable_cnt=1 and the previous sample is updated.
  - timeout_cnt++ every cycle.
  - When stable_cnt reaches STABLE_CYCLES: rsp_data_o=sync_q, rsp_timeout_o=0, go to RESP.
  - Else when timeout_cnt reaches TIMEOUT_CYCLES: rsp_data_o=last sample, rsp_timeout_o=1, go to RESP.
  - If both conditions hit in the same cycle, stable wins.
- RESP:
  - rsp_valid_o=1, with rsp_* held constant until rsp_ready_i.
  - On handshake: pad_sel_o returns to 0 on the next cycle, pad_in_o keeps its value, go to IDLE.
  - A new command can be accepted one cycle after the response handshake; there is no overlap.
- Minimum command latency, accept to rsp_valid_o:
  - Nonzero sel: 1 + SETUP_CYCLES + STABLE_CYCLES cycles, ignoring the synchroniser's 2-cycle input delay already in flight.
  - sel=0: 1 cycle.
- Counters saturate; no wrap-around is possible within the parameter ranges.
- Reset mid-operation forces the reset values immediately. Any pending response is lost and the pads return to 0.
- cmd_* inputs are ignored unless the handshake occurs. rsp_ready_i is ignored outside RESP.

Test Plan:
- Reset, then cmd sel=1, data=0x2AAAAA, pad_out_i held at 0x15A5A → pads show sel=1/0x2AAAAA; rsp_valid rises 8 cycles after accept (defaults) with data=0x15A5A, timeout=0, rsp_sel=1; pad_sel returns to 0 after the handshake.
- Cmd sel=3, pad_out_i toggling between 0x00001 and 0x00002 every cycle → rsp_timeout=1 exactly TIMEOUT_CYCLES after SAMPLE entry; data equals the last sample.
- Cmd sel=2, pad_out_i glitches once during SAMPLE then settles at 0x3FFFF → stable count restarts; rsp_data=0x3FFFF with no timeout.
- rsp_ready_i held low for 20 cycles, with cmd_valid_i asserted throughout → rsp_* stable, cmd_ready_o=0; next command accepted 1 cycle after the handshake.
- Cmd sel=0 → response the next cycle with data=0 and pads untouched; back-to-back sel=0 commands are answered every 2 cycles.
- Assert resetn_i during SAMPLE → all outputs take reset values asynchronously; after release, a new command completes normally.
